// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package program_loader_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    WRITE,
    DONE,
    ERROR
  } state_e;

  // Big-endian assembly: earlier bytes end up in the high-order lanes.
  function automatic logic [WORD_W-1:0] shift_in(input logic [WORD_W-1:0] w,
                                                 input logic [BYTE_W-1:0] b);
    return {w[WORD_W-BYTE_W-1:0], b};
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface program_loader_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/program_loader_byte_packer.sv
// Shifts accepted bytes into a 32-bit word and flags the byte that completes it.
module program_loader_byte_packer
  import program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] in_byte,
  output logic [WORD_W-1:0] word_c,
  output logic              word_ready_c
);

  localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);

  logic [WORD_W-1:0] word_q;
  logic [CNT_W-1:0]  cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (clear) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (shift_en) begin
      word_q <= shift_in(word_q, in_byte);
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

  // Word as it will look once the current byte is shifted in.
  assign word_c       = shift_in(word_q, in_byte);
  assign word_ready_c = shift_en && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed big-endian word image into instruction memory, then releases the CPU.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  program_loader_if.slave  bus,
  output logic             cpu_reset,
  output logic             done,
  output logic             error
);

  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
  localparam int unsigned WCNT_W = ADDR_WIDTH + 1;

  state_e                 state;
  logic                   in_ready_q;
  logic                   mem_we_q;
  logic [ADDR_WIDTH-1:0]  mem_addr_q;
  logic [WORD_W-1:0]      mem_wdata_q;
  logic [BYTE_W-1:0]      n_hi_q;
  logic [CNT_WIDTH-1:0]   n_words_q;
  logic [WCNT_W-1:0]      word_cnt_q;

  logic                   xfer_c;
  logic                   pack_clear_c;
  logic                   word_ready_c;
  logic                   last_word_c;
  logic [CNT_WIDTH-1:0]   hdr_n_c;
  logic [WORD_W-1:0]      packed_word_c;

  assign xfer_c       = bus.in_valid && in_ready_q;
  assign pack_clear_c = start && ((state == DONE) || (state == ERROR));
  assign hdr_n_c      = CNT_WIDTH'({n_hi_q, bus.in_data});
  // Word counter is one bit wider than the address so a full-depth image never wraps.
  assign last_word_c  = (32'(word_cnt_q) + 32'd1) == 32'(n_words_q);

  program_loader_byte_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear        (pack_clear_c),
    .shift_en     (xfer_c && (state == DATA)),
    .in_byte      (bus.in_data),
    .word_c       (packed_word_c),
    .word_ready_c (word_ready_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= HDR_HI;
      in_ready_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_reset   <= 1'b1;
      done        <= 1'b0;
      error       <= 1'b0;
      n_hi_q      <= '0;
      n_words_q   <= '0;
      word_cnt_q  <= '0;
    end else begin
      mem_we_q <= 1'b0;
      case (state)
        HDR_HI: begin
          if (xfer_c) begin
            n_hi_q <= bus.in_data;
            state  <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (xfer_c) begin
            n_words_q <= hdr_n_c;
            if (hdr_n_c == '0) begin
              state      <= DONE;
              in_ready_q <= 1'b0;
              cpu_reset  <= 1'b0;
              done       <= 1'b1;
            end else if (32'(hdr_n_c) > DEPTH) begin
              state      <= ERROR;
              in_ready_q <= 1'b0;
              error      <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (word_ready_c) begin
            state       <= WRITE;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= word_cnt_q[ADDR_WIDTH-1:0];
            mem_wdata_q <= packed_word_c;
          end
        end
        WRITE: begin
          word_cnt_q <= word_cnt_q + WCNT_W'(1);
          if (last_word_c) begin
            state     <= DONE;
            cpu_reset <= 1'b0;
            done      <= 1'b1;
          end else begin
            state      <= DATA;
            in_ready_q <= 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            state      <= HDR_HI;
            in_ready_q <= 1'b1;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            word_cnt_q <= '0;
          end
        end
        ERROR: begin
          if (start) begin
            state      <= HDR_HI;
            in_ready_q <= 1'b1;
            error      <= 1'b0;
            word_cnt_q <= '0;
          end
        end
        default: begin
          state      <= HDR_HI;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time stage that sits directly upstream of the single-cycle MIPS processor.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes those words sequentially into the processor's 256-word instruction memory.
- Holds the processor in reset until the whole image is loaded, then releases it.

Parameters:
- ADDR_WIDTH, 8, word-address width of the instruction memory; depth = 2^ADDR_WIDTH words.
- CNT_WIDTH, 16, width of the word-count header field.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; restarts loading from DONE or ERROR. Ignored in all other states.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle. A byte transfers when in_valid && in_ready at the clock edge.
- mem_we  output  1  instruction-memory write enable.
- mem_addr  output  ADDR_WIDTH  word address of the write.
- mem_wdata  output  32  word to write.
- cpu_reset  output  1  active-high reset to the processor; 1 except in DONE.
- done  output  1  image loaded; processor running.
- error  output  1  header word count exceeds memory depth.

Behaviour:
- Reset (reset=0, async):
  - state=HDR_HI, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_reset=1, done=0, error=0.
  - Byte counter, word counter and shift register cleared.
- Stream format:
  - 2 header bytes form word count N, big-endian (high byte first).
  - N words follow, each 4 bytes, most-significant byte first.
- HDR_HI: in_ready=1. On transfer, latch N[15:8] → HDR_LO.
- HDR_LO: in_ready=1. On transfer, latch N[7:0], then:
  - N=0 → DONE.
  - N > 2^ADDR_WIDTH → ERROR.
  - otherwise → DATA.
- DATA:
  - in_ready=1. Each transfer shifts the byte into a 32-bit register: word = {word[23:0], in_data}.
  - A 2-bit byte counter increments on each transfer.
  - The 4th transfer (counter=3) → WRITE.
- WRITE (exactly one cycle):
  - in_ready=0, mem_we=1, mem_wdata=assembled word, mem_addr=word counter.
  - Next edge: word counter increments.
  - If the word counter was N-1 → DONE; otherwise → DATA.
  - Latency: 4th byte accepted at edge k → mem_we high for the cycle after edge k.
  - Minimum 5 cycles per word.
- DONE: in_ready=0, mem_we=0, cpu_reset=0, done=1. start → HDR_HI with cpu_reset=1, done=0, counters cleared.
- ERROR: in_ready=0, mem_we=0, cpu_reset=1, error=1. start → HDR_HI with error=0.
- mem_we is asserted only in WRITE.
- mem_addr and mem_wdata hold their last values outside WRITE.
- Boundary conditions:
  - in_valid low mid-word: the shift register and byte counter hold; no timeout.
  - in_valid while in_ready=0: the byte is not consumed; the source must hold it.
  - N = 2^ADDR_WIDTH: the word counter is ADDR_WIDTH+1 bits wide, so the final write goes to the last address with no wrap.
  - start outside DONE/ERROR: ignored.
  - Reset mid-load: immediate return to HDR_HI; already-written memory contents are not cleared.
- cpu_reset is registered, so it is glitch-free and deasserts on the edge that enters DONE.

Decomposition:
- Shared package:
  - State enumeration: HDR_HI, HDR_LO, DATA, WRITE, DONE, ERROR.
  - Header byte count constant (2).
  - Bytes-per-word constant (4).
- Sub-module: byte_packer.
  - Contains the shift register, the 2-bit byte counter and the word_ready strobe.
  - Has a clear input driven by the FSM.
- The FSM and counters stay in program_loader.

Test Plan:
- Header 0x00,0x02 then bytes 20 08 00 05 / 21 29 FF FF:
  - Writes 0x20080005 at addr 0 and 0x2129FFFF at addr 1.
  - done=1, cpu_reset falls on the edge after the second WRITE.
  - Processor then fetches 0x20080005 at PC 0.
- Header 0x00,0x00: DONE two edges after the first header byte; mem_we is never asserted.
- Header 0x01,0x01 (257 > 256): error=1, cpu_reset=1, in_ready=0. A start pulse then returns to HDR_HI with error=0.
- Random in_valid gaps (about 50% duty) during a 3-word load:
  - Word values identical to the gap-free run.
  - mem_we is high exactly 3 cycles.
  - in_ready=0 in each WRITE cycle.
- reset pulled low after 2 bytes of word 1: all outputs return to their reset values asynchronously. A full reload afterwards writes correct words from addr 0.
- Header 0x01,0x00 with 256 words: the last write goes to addr 0xFF with data equal to the final 4 bytes, then done=1.
